lock_ctrl: RTL and testbench

LOCK_CTRL -- requirements
Module: lock_ctrl

---
 rtl/lock_ctrl_pkg.sv | 17 +
 rtl/lock_timer.sv | 15 +
 rtl/lock_ctrl.sv | 123 ++++++++++++
 tb/tb_lock_ctrl.sv | 104 ++++++++++
 4 files changed

// File: rtl/lock_ctrl_pkg.sv
// lock_ctrl_pkg: lock_ctrl state encoding, datapath mode constants and mode lookup
package lock_ctrl_pkg;
  typedef enum logic [2:0] {
    LOCKED    = 3'd0,
    PROG_AUTH = 3'd1,
    NEW_CODE  = 3'd2,
    CONFIRM   = 3'd3,
    OPEN      = 3'd4,
    LOCKOUT   = 3'd5
  } state_t;
  localparam logic [1:0] PROGRAM_CODE    = 2'b00;
  localparam logic [1:0] USER_CODE_VALID = 2'b01;
  localparam logic [1:0] USER_CODE_EQUAL = 2'b10;
  function automatic logic [1:0] mode_of(state_t s);
    return s == PROG_AUTH ? PROGRAM_CODE : s == CONFIRM ? USER_CODE_EQUAL : USER_CODE_VALID;
  endfunction
endpackage

// File: rtl/lock_timer.sv
// lock_timer: loadable 32-bit down-counter (clk, rst, load, load_val in; done out, high on the last counted cycle)
module lock_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        done
);
  logic [31:0] count;
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (load) count <= load_val;
    else if (count != '0) count <= count - 32'd1;
  assign done = count == 32'd1;
endmodule

// File: rtl/lock_ctrl.sv
// lock_ctrl: keypad lock FSM (enter/prog/lock pulses, datapath flags in; mode, entry_rst, code_saved, unlocked, lockout, fail_cnt, state_dbg out); LOCK_CTRL_AUTORELOCK_EN enables OPEN timeout
module lock_ctrl
  import lock_ctrl_pkg::*;
#(
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1000,
  parameter int unsigned UNLOCK_CYCLES  = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter,
  input  logic       prog,
  input  logic       lock,
  input  logic       correct,
  input  logic       valid,
  input  logic       equal,
  input  logic       code_match,
  output logic [1:0] is_programming,
  output logic       entry_rst,
  output logic       code_saved,
  output logic       unlocked,
  output logic       lockout,
  output logic [3:0] fail_cnt,
  output logic [2:0] state_dbg
);
  localparam logic [3:0] MAX = 4'(MAX_TRIES);
  state_t state, state_n;
  logic [3:0] fail_n, fail_inc;
  logic entry_rst_n, code_saved_n, t_load, t_done;
  logic [31:0] t_val;
  assign fail_inc = fail_cnt >= MAX ? MAX : fail_cnt + 4'd1;
  lock_timer u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (t_load),
    .load_val(t_val),
    .done    (t_done)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state      <= LOCKED;
      fail_cnt   <= '0;
      entry_rst  <= 1'b0;
      code_saved <= 1'b0;
    end else begin
      state      <= state_n;
      fail_cnt   <= fail_n;
      entry_rst  <= entry_rst_n;
      code_saved <= code_saved_n;
    end
  always_comb begin
    state_n      = state;
    fail_n       = fail_cnt;
    entry_rst_n  = 1'b0;
    code_saved_n = 1'b0;
    case (state)
      LOCKED:
        if (enter) begin
          entry_rst_n = 1'b1;
          if (valid && code_match) begin
            state_n = OPEN;
            fail_n  = '0;
          end else begin
            fail_n  = fail_inc;
            state_n = fail_inc == MAX ? LOCKOUT : LOCKED;
          end
        end else if (prog) begin
          state_n     = PROG_AUTH;
          entry_rst_n = 1'b1;
        end
      PROG_AUTH:
        if (enter) begin
          entry_rst_n = 1'b1;
          if (correct) begin
            state_n = NEW_CODE;
            fail_n  = '0;
          end else begin
            fail_n  = fail_inc;
            state_n = fail_inc == MAX ? LOCKOUT : LOCKED;
          end
        end
      NEW_CODE:
        if (enter) begin
          state_n     = valid ? CONFIRM : NEW_CODE;
          entry_rst_n = !valid;
        end
      CONFIRM:
        if (enter) begin
          state_n      = equal ? LOCKED : NEW_CODE;
          code_saved_n = equal;
          entry_rst_n  = 1'b1;
        end
      OPEN:
`ifdef LOCK_CTRL_AUTORELOCK_EN
        if (lock || t_done) begin
`else
        if (lock) begin
`endif
          state_n     = LOCKED;
          entry_rst_n = 1'b1;
        end
      LOCKOUT:
        if (t_done) begin
          state_n     = LOCKED;
          fail_n      = '0;
          entry_rst_n = 1'b1;
        end
      default: state_n = LOCKED;
    endcase
`ifdef LOCK_CTRL_AUTORELOCK_EN
    t_load = state_n != state && (state_n == LOCKOUT || state_n == OPEN);
`else
    t_load = state_n != state && state_n == LOCKOUT;
`endif
    t_val = state_n == OPEN ? 32'(UNLOCK_CYCLES) : 32'(LOCKOUT_CYCLES);
  end
  always_comb begin
    is_programming = mode_of(state);
    unlocked       = state == OPEN;
    lockout        = state == LOCKOUT;
    state_dbg      = state;
  end
endmodule

// File: tb/tb_lock_ctrl.sv
// tb_lock_ctrl: scoreboard bench for lock_ctrl with MAX_TRIES=3, LOCKOUT_CYCLES=16, UNLOCK_CYCLES=8
module tb_lock_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic enter = 1'b0, prog = 1'b0, lock = 1'b0;
  logic correct = 1'b0, valid = 1'b0, equal = 1'b0, code_match = 1'b0;
  logic [1:0] is_programming;
  logic entry_rst, code_saved, unlocked, lockout;
  logic [3:0] fail_cnt;
  logic [2:0] state_dbg;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [2:0] st;
    logic [3:0] fc;
    logic       er;
    logic       cs;
  } exp_t;
  exp_t sb[$];
  localparam logic [2:0] S_LK = 3'd0, S_PA = 3'd1, S_NC = 3'd2, S_CF = 3'd3, S_OP = 3'd4, S_LO = 3'd5;
  always #5 clk = ~clk;
  lock_ctrl #(.MAX_TRIES(3), .LOCKOUT_CYCLES(16), .UNLOCK_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .enter(enter), .prog(prog), .lock(lock),
    .correct(correct), .valid(valid), .equal(equal), .code_match(code_match),
    .is_programming(is_programming), .entry_rst(entry_rst), .code_saved(code_saved),
    .unlocked(unlocked), .lockout(lockout), .fail_cnt(fail_cnt), .state_dbg(state_dbg)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [1:0] exp_mode(input logic [2:0] s);
    return s == S_PA ? 2'b00 : s == S_CF ? 2'b10 : 2'b01;
  endfunction
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("state", 32'(state_dbg), 32'(e.st));
      check("fail_cnt", 32'(fail_cnt), 32'(e.fc));
      check("entry_rst", 32'(entry_rst), 32'(e.er));
      check("code_saved", 32'(code_saved), 32'(e.cs));
      check("unlocked", 32'(unlocked), 32'(e.st == S_OP));
      check("lockout", 32'(lockout), 32'(e.st == S_LO));
      check("mode", 32'(is_programming), 32'(exp_mode(e.st)));
    end
  end
  task automatic step(input logic r, en, pg, lk, cor, val, eq, cm,
                      input logic [2:0] st, input logic [3:0] fc, input logic er, cs);
    exp_t e;
    @(negedge clk);
    rst = r; enter = en; prog = pg; lock = lk;
    correct = cor; valid = val; equal = eq; code_match = cm;
    e.st = st; e.fc = fc; e.er = er; e.cs = cs;
    sb.push_back(e);
  endtask
  task automatic idle(input logic [2:0] st, input logic [3:0] fc, input logic er);
    step(0, 0, 0, 0, 0, 0, 0, 0, st, fc, er, 0);
  endtask
  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, S_LK, 0, 0, 0);
    idle(S_LK, 0, 0);
    step(0, 1, 0, 0, 0, 1, 0, 1, S_OP, 0, 1, 0);
    for (int i = 1; i <= 7; i++)
      step(0, i == 3, i == 3, 0, 0, 1, 0, 1, S_OP, 0, 0, 0);
`ifdef LOCK_CTRL_AUTORELOCK_EN
    idle(S_LK, 0, 1);
    step(0, 0, 0, 1, 0, 0, 0, 0, S_LK, 0, 0, 0);
`else
    idle(S_OP, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, S_LK, 0, 1, 0);
`endif
    step(0, 1, 0, 0, 0, 1, 0, 0, S_LK, 1, 1, 0);
    idle(S_LK, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1, S_LK, 2, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, S_LO, 3, 1, 0);
    for (int i = 1; i <= 15; i++)
      step(0, i % 2 == 1, i % 3 == 0, i == 4, 1, 1, 1, 1, S_LO, 3, 0, 0);
    idle(S_LK, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0, 0, S_PA, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 1, 1, S_LK, 1, 1, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, S_PA, 1, 1, 0);
    step(0, 1, 0, 0, 1, 0, 0, 0, S_NC, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, S_NC, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, S_CF, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, S_NC, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, S_CF, 0, 0, 0);
    idle(S_CF, 0, 0);
    step(0, 1, 0, 0, 0, 0, 1, 0, S_LK, 0, 1, 1);
    idle(S_LK, 0, 0);
    step(0, 1, 1, 0, 0, 1, 0, 1, S_OP, 0, 1, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, S_LK, 0, 1, 0);
    step(0, 1, 1, 0, 0, 1, 0, 0, S_LK, 1, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, S_LK, 2, 1, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, S_LO, 3, 1, 0);
    for (int i = 1; i <= 4; i++) idle(S_LO, 3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, S_LK, 0, 0, 0);
    for (int i = 0; i < 20; i++) idle(S_LK, 0, 0);
    @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
